// File: rtl/arr_pack_sched_if.sv
// Handshake bundle for arr_pack_sched: two byte requesters, the packed-word
// consumer and the frame fill count.
interface arr_pack_sched_if #(
    parameter int DATA_W = 8
);
    logic                  a_valid;
    logic [DATA_W-1:0]     a_data;
    logic                  a_ready;
    logic                  b_valid;
    logic [DATA_W-1:0]     b_data;
    logic                  b_ready;
    logic                  out_valid;
    logic [2*DATA_W-1:0]   out_data;
    logic                  out_ready;
    logic [2:0]            fill_cnt;

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, fill_cnt
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, fill_cnt
    );
endinterface

// File: rtl/arr_pack_sched.sv
// Two-requester byte collector: fills a 4-entry array with round-robin
// arbitration on contention, then drains it as two packed 2*DATA_W words.
module arr_pack_sched #(
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    arr_pack_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        FILL     = 2'd0,
        DRAIN_LO = 2'd1,
        DRAIN_HI = 2'd2
    } state_t;

    state_t                state_r;
    logic [1:0]            wr_ptr_r;
    logic [2:0]            fill_cnt_r;
    logic                  prio_b_r;
    logic [DATA_W-1:0]     arr_r [4];
    logic                  out_valid_r;
    logic [2*DATA_W-1:0]   out_data_r;

    logic                  grant_a_s;
    logic                  grant_b_s;
    logic                  contend_s;
    logic                  wr_en_s;
    logic [DATA_W-1:0]     wr_data_s;

    // Arbitration: grants only while filling; priority bit breaks ties.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        contend_s = bus.a_valid && bus.b_valid;
        if (state_r == FILL) begin
            if (contend_s) begin
                grant_a_s = !prio_b_r;
                grant_b_s = prio_b_r;
            end else begin
                grant_a_s = bus.a_valid;
                grant_b_s = bus.b_valid;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
        wr_en_s   = grant_a_s || grant_b_s;
        wr_data_s = grant_a_s ? bus.a_data : bus.b_data;
    end

    // Frame state machine, array storage and registered output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= FILL;
            wr_ptr_r    <= 2'd0;
            fill_cnt_r  <= 3'd0;
            prio_b_r    <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {(2*DATA_W){1'b0}};
            for (int i = 0; i < 4; i++) begin
                arr_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            case (state_r)
                FILL: begin
                    if (wr_en_s) begin
                        arr_r[wr_ptr_r] <= wr_data_s;
                        wr_ptr_r        <= wr_ptr_r + 2'd1;
                        fill_cnt_r      <= fill_cnt_r + 3'd1;
                        if (contend_s) begin
                            prio_b_r <= !prio_b_r;
                        end
                        // Entries 0 and 1 are already stored when the last byte lands.
                        if (wr_ptr_r == 2'd3) begin
                            state_r     <= DRAIN_LO;
                            out_valid_r <= 1'b1;
                            out_data_r  <= {arr_r[0], arr_r[1]};
                        end
                    end
                end
                DRAIN_LO: begin
                    if (bus.out_ready) begin
                        out_data_r <= {arr_r[2], arr_r[3]};
                        state_r    <= DRAIN_HI;
                    end
                end
                DRAIN_HI: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        wr_ptr_r    <= 2'd0;
                        fill_cnt_r  <= 3'd0;
                        state_r     <= FILL;
                    end
                end
                default: begin
                    state_r <= FILL;
                end
            endcase
        end
    end

    assign bus.a_ready   = grant_a_s;
    assign bus.b_ready   = grant_b_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.fill_cnt  = fill_cnt_r;
endmodule

// File: tb/tb_arr_pack_sched.sv
// Directed bench for arr_pack_sched: solo fill, alternating contention,
// backpressure, mixed priority, reset mid-drain and a 4-bit lane build.
module tb_arr_pack_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arr_pack_sched_if #(.DATA_W(8)) bus8 ();
    arr_pack_sched_if #(.DATA_W(4)) bus4 ();

    arr_pack_sched #(.DATA_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    arr_pack_sched #(.DATA_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int total = 0;
    int bad   = 0;

    logic [7:0] t1_d  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] t2_a  [4] = '{8'hA0, 8'hEE, 8'hA1, 8'hEE};
    logic [7:0] t2_b  [4] = '{8'hB0, 8'hB0, 8'hB1, 8'hB1};
    logic       t2_ea [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       t3_av [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] t3_a  [4] = '{8'h31, 8'h00, 8'h33, 8'h00};
    logic [7:0] t3_b  [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    logic       t3_ea [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] t4_a  [4] = '{8'h51, 8'h52, 8'h53, 8'h54};
    logic [7:0] t4_b  [4] = '{8'h61, 8'h62, 8'h63, 8'h64};
    logic [3:0] t5_n  [4] = '{4'hA, 4'hB, 4'hC, 4'hD};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus8.a_valid = 1'b0; bus8.a_data = 8'h00; bus8.b_valid = 1'b0;
        bus8.b_data = 8'h00; bus8.out_ready = 1'b0;
        bus4.a_valid = 1'b0; bus4.a_data = 4'h0; bus4.b_valid = 1'b0;
        bus4.b_data = 4'h0; bus4.out_ready = 1'b0;

        #2;
        check("rst_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_data",  32'(bus8.out_data),  32'h0);
        check("rst_fill",  32'(bus8.fill_cnt),  32'd0);
        check("rst_ardy",  32'(bus8.a_ready),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Solo A frame, preceded by an idle cycle with junk data.
        bus8.a_data = 8'hFF;
        @(negedge clk);
        check("idle_ardy", 32'(bus8.a_ready), 32'd0);
        tick();
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus8.a_valid = 1'b1;
            bus8.a_data  = t1_d[i];
            @(negedge clk);
            check("t1_ardy", 32'(bus8.a_ready), 32'd1);
            check("t1_brdy", 32'(bus8.b_ready), 32'd0);
            check("t1_fill", 32'(bus8.fill_cnt), 32'(i));
            tick();
        end
        bus8.a_valid = 1'b0;
        @(negedge clk);
        check("t1_vlo",   32'(bus8.out_valid), 32'd1);
        check("t1_lo",    32'(bus8.out_data),  32'h1122);
        check("t1_fill4", 32'(bus8.fill_cnt),  32'd4);
        tick();
        @(negedge clk);
        check("t1_vhi", 32'(bus8.out_valid), 32'd1);
        check("t1_hi",  32'(bus8.out_data),  32'h3344);
        tick();
        @(negedge clk);
        check("t1_vdone", 32'(bus8.out_valid), 32'd0);
        check("t1_fill0", 32'(bus8.fill_cnt),  32'd0);

        // Contention from reset, then 5 cycles of backpressure.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        bus8.a_valid = 1'b1;
        bus8.b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus8.a_data = t2_a[i];
            bus8.b_data = t2_b[i];
            @(negedge clk);
            check("t2_ardy", 32'(bus8.a_ready), 32'(t2_ea[i]));
            check("t2_brdy", 32'(bus8.b_ready), 32'(!t2_ea[i]));
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_stall_v",    32'(bus8.out_valid), 32'd1);
            check("t2_stall_d",    32'(bus8.out_data),  32'hA0B0);
            check("t2_stall_ardy", 32'(bus8.a_ready),   32'd0);
            check("t2_stall_brdy", 32'(bus8.b_ready),   32'd0);
            tick();
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        check("t2_lo", 32'(bus8.out_data), 32'hA0B0);
        tick();
        bus8.a_valid = 1'b0;
        bus8.b_valid = 1'b0;
        @(negedge clk);
        check("t2_hi", 32'(bus8.out_data), 32'hA1B1);
        tick();
        @(negedge clk);
        check("t2_vdone", 32'(bus8.out_valid), 32'd0);
        tick();

        // Contended / solo-B alternation: priority moves only on contention.
        for (int i = 0; i < 4; i++) begin
            bus8.a_valid = t3_av[i];
            bus8.b_valid = 1'b1;
            bus8.a_data  = t3_a[i];
            bus8.b_data  = t3_b[i];
            @(negedge clk);
            check("t3_ardy", 32'(bus8.a_ready), 32'(t3_ea[i]));
            check("t3_brdy", 32'(bus8.b_ready), 32'(!t3_ea[i]));
            tick();
        end
        bus8.a_valid = 1'b0;
        bus8.b_valid = 1'b0;
        @(negedge clk);
        check("t3_lo", 32'(bus8.out_data), 32'h3142);
        tick();
        @(negedge clk);
        check("t3_hi", 32'(bus8.out_data), 32'h4344);
        tick();
        bus8.a_valid = 1'b1;
        bus8.b_valid = 1'b1;
        @(negedge clk);
        check("t3_prio_ardy", 32'(bus8.a_ready), 32'd1);
        check("t3_prio_brdy", 32'(bus8.b_ready), 32'd0);
        bus8.a_valid = 1'b0;
        bus8.b_valid = 1'b0;

        // Reset asserted while in DRAIN_HI; next frame must hold only fresh bytes.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus8.a_valid = 1'b1;
            bus8.a_data  = t4_a[i];
            @(negedge clk);
            check("t4_ardy", 32'(bus8.a_ready), 32'd1);
            tick();
        end
        bus8.a_valid = 1'b0;
        @(negedge clk);
        check("t4_lo", 32'(bus8.out_data), 32'h5152);
        tick();
        @(negedge clk);
        check("t4_hi", 32'(bus8.out_data), 32'h5354);
        rst_n = 1'b0;
        #1;
        check("t4_rst_v",    32'(bus8.out_valid), 32'd0);
        check("t4_rst_fill", 32'(bus8.fill_cnt),  32'd0);
        check("t4_rst_data", 32'(bus8.out_data),  32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus8.b_valid = 1'b1;
            bus8.b_data  = t4_b[i];
            @(negedge clk);
            check("t4_brdy", 32'(bus8.b_ready), 32'd1);
            check("t4_fill", 32'(bus8.fill_cnt), 32'(i));
            tick();
        end
        bus8.b_valid = 1'b0;
        @(negedge clk);
        check("t4_new_lo", 32'(bus8.out_data), 32'h6162);
        tick();
        @(negedge clk);
        check("t4_new_hi", 32'(bus8.out_data), 32'h6364);
        tick();

        // 4-bit lane build.
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus4.a_valid = 1'b1;
            bus4.a_data  = t5_n[i];
            @(negedge clk);
            check("t5_ardy", 32'(bus4.a_ready), 32'd1);
            tick();
        end
        bus4.a_valid = 1'b0;
        @(negedge clk);
        check("t5_lo", 32'(bus4.out_data), 32'hAB);
        tick();
        @(negedge clk);
        check("t5_hi", 32'(bus4.out_data), 32'hCD);
        tick();
        @(negedge clk);
        check("t5_vdone", 32'(bus4.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
